// File: rtl/lsu_pkg.sv
// Shared constants and types for the load/store unit.
package lsu_pkg;

    // funct3 access size/sign encodings
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // error codes reported on err_code
    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_ILLEGAL  = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    // Classify a request; illegal encodings take priority over misalignment.
    function automatic logic [1:0] classify_req(input logic rd, input logic wr,
                                                input logic [2:0] f3,
                                                input logic [1:0] addr_lo);
        logic [1:0] code;
        if (rd && wr) begin
            code = ERR_ILLEGAL;
        end else if ((f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111)) begin
            code = ERR_ILLEGAL;
        end else if (wr && f3[2]) begin
            code = ERR_ILLEGAL;
        end else if ((f3[1:0] == 2'b01) && addr_lo[0]) begin
            code = ERR_MISALIGN;
        end else if ((f3[1:0] == 2'b10) && (addr_lo != 2'b00)) begin
            code = ERR_MISALIGN;
        end else begin
            code = ERR_NONE;
        end
        return code;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store replication/mask and load extract/extend.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] st_data,
    input  logic [31:0] ld_word,
    output logic [31:0] st_word,
    output logic [3:0]  st_mask,
    output logic [31:0] ld_data
);

    logic [7:0]  ld_byte_s;
    logic [15:0] ld_half_s;

    // Store side: replicate the datum across lanes and mark the touched bytes.
    always_comb begin
        st_word = st_data;
        st_mask = 4'b1111;
        case (funct3[1:0])
            2'b00: begin
                st_word = {4{st_data[7:0]}};
                st_mask = 4'b0001 << addr_lo;
            end
            2'b01: begin
                st_word = {2{st_data[15:0]}};
                st_mask = addr_lo[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                st_word = st_data;
                st_mask = 4'b1111;
            end
        endcase
    end

    // Load side: pick the addressed lane, then sign- or zero-extend.
    always_comb begin
        case (addr_lo)
            2'b00:   ld_byte_s = ld_word[7:0];
            2'b01:   ld_byte_s = ld_word[15:8];
            2'b10:   ld_byte_s = ld_word[23:16];
            2'b11:   ld_byte_s = ld_word[31:24];
            default: ld_byte_s = 8'h00;
        endcase
        if (addr_lo[1]) begin
            ld_half_s = ld_word[31:16];
        end else begin
            ld_half_s = ld_word[15:0];
        end
        case (funct3)
            F3_B:    ld_data = {{24{ld_byte_s[7]}}, ld_byte_s};
            F3_BU:   ld_data = {24'h000000, ld_byte_s};
            F3_H:    ld_data = {{16{ld_half_s[15]}}, ld_half_s};
            F3_HU:   ld_data = {16'h0000, ld_half_s};
            default: ld_data = ld_word;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller: MEM-stage request -> word-aligned memory handshake.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRead_M,
    input  logic        MemWrite_M,
    input  logic [2:0]  funct3_M,
    input  logic [31:0] addr_M,
    input  logic [31:0] wdata_M,
    output logic        stall_M,
    output logic [31:0] ReadData_M,
    output logic        err,
    output logic [1:0]  err_code,
    output logic        mem_valid,
    output logic        mem_wen,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [7:0]  mem_wmask,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);

    localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT);

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        to_q, to_d;

    logic        req_s;
    logic        legal_s;
    logic [1:0]  chk_s;
    logic [31:0] st_word_s;
    logic [3:0]  st_mask_s;
    logic [31:0] ld_data_s;

    lsu_align u_align (
        .funct3  (funct3_M),
        .addr_lo (addr_M[1:0]),
        .st_data (wdata_M),
        .ld_word (rdata_q),
        .st_word (st_word_s),
        .st_mask (st_mask_s),
        .ld_data (ld_data_s)
    );

    // Decode the MEM-stage request into legal / error class.
    always_comb begin
        req_s   = MemRead_M | MemWrite_M;
        chk_s   = classify_req(MemRead_M, MemWrite_M, funct3_M, addr_M[1:0]);
        legal_s = req_s && (chk_s == ERR_NONE);
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers: wait counter, captured read word, timeout flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q   <= 8'd0;
            rdata_q <= 32'h0000_0000;
            to_q    <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            to_q    <= to_d;
        end
    end

    // Next-state logic; a ready on the final counted cycle wins over timeout.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        to_d    = to_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = 8'd0;
                to_d  = 1'b0;
                if (legal_s) begin
                    state_d = ST_ACCESS;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (mem_ready) begin
                    rdata_d = mem_rdata;
                    to_d    = 1'b0;
                    state_d = ST_DONE;
                end else if ((cnt_q + 8'd1) == TO_LIMIT) begin
                    rdata_d = 32'h0000_0000;
                    to_d    = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    cnt_d   = cnt_q + 8'd1;
                    state_d = ST_ACCESS;
                end
            end
            ST_DONE: begin
                cnt_d   = 8'd0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs: combinational from state and MEM inputs, forced quiet while in reset.
    always_comb begin
        stall_M    = 1'b0;
        ReadData_M = 32'h0000_0000;
        err        = 1'b0;
        err_code   = ERR_NONE;
        mem_valid  = 1'b0;
        mem_wen    = 1'b0;
        mem_addr   = 32'h0000_0000;
        mem_wdata  = 32'h0000_0000;
        mem_wmask  = 8'h00;
        if (rst) begin
            case (state_q)
                ST_IDLE: begin
                    if (legal_s) begin
                        stall_M = 1'b1;
                    end else if (req_s) begin
                        err      = 1'b1;
                        err_code = chk_s;
                    end else begin
                        stall_M = 1'b0;
                    end
                end
                ST_ACCESS: begin
                    stall_M   = 1'b1;
                    mem_valid = 1'b1;
                    mem_wen   = MemWrite_M;
                    mem_addr  = {addr_M[31:2], 2'b00};
                    if (MemWrite_M) begin
                        mem_wdata = st_word_s;
                        mem_wmask = {4'b0000, st_mask_s};
                    end else begin
                        mem_wdata = 32'h0000_0000;
                        mem_wmask = 8'h00;
                    end
                end
                ST_DONE: begin
                    ReadData_M = ld_data_s;
                    err        = to_q;
                    err_code   = to_q ? ERR_TIMEOUT : ERR_NONE;
                end
                default: begin
                    stall_M = 1'b0;
                end
            endcase
        end else begin
            stall_M = 1'b0;
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: directed transactions against a behavioural model.
module tb_lsu_ctrl;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        MemRead_M, MemWrite_M;
    logic [2:0]  funct3_M;
    logic [31:0] addr_M, wdata_M;
    logic        stall_M;
    logic [31:0] ReadData_M;
    logic        err;
    logic [1:0]  err_code;
    logic        mem_valid, mem_wen;
    logic [31:0] mem_addr, mem_wdata;
    logic [7:0]  mem_wmask;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    always #5 clk = ~clk;

    lsu_ctrl #(.TIMEOUT(T)) dut (
        .clk        (clk),
        .rst        (rst),
        .MemRead_M  (MemRead_M),
        .MemWrite_M (MemWrite_M),
        .funct3_M   (funct3_M),
        .addr_M     (addr_M),
        .wdata_M    (wdata_M),
        .stall_M    (stall_M),
        .ReadData_M (ReadData_M),
        .err        (err),
        .err_code   (err_code),
        .mem_valid  (mem_valid),
        .mem_wen    (mem_wen),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wmask  (mem_wmask),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready)
    );

    int total = 0;
    int bad   = 0;

    // expected outputs for the current cycle
    logic        chk_en = 1'b0;
    logic        e_stall, e_valid, e_err, e_wen, chk_wd, chk_rd;
    logic [1:0]  e_code;
    logic [31:0] e_addr, e_wdata, e_rd;
    logic [3:0]  e_mask;
    logic [31:0] seen_rd, seen_wdata;
    logic [7:0]  seen_mask;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic int acc_size(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        else if (f3[1:0] == 2'b01) return 2;
        else return 4;
    endfunction

    function automatic logic [1:0] ref_code(input logic rd, input logic wr,
                                            input logic [2:0] f3, input logic [31:0] a);
        int f = int'(f3);
        if (rd && wr) return 2'b10;
        if (!(f == 0 || f == 1 || f == 2 || f == 4 || f == 5)) return 2'b10;
        if (wr && f >= 4) return 2'b10;
        if ((int'(a[1:0]) % acc_size(f3)) != 0) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [31:0] ref_st_word(input logic [2:0] f3, input logic [31:0] wd);
        int s = acc_size(f3);
        if (s == 1) return (wd & 32'h0000_00FF) * 32'h0101_0101;
        if (s == 2) return (wd & 32'h0000_FFFF) * 32'h0001_0001;
        return wd;
    endfunction

    function automatic logic [3:0] ref_st_mask(input logic [2:0] f3, input logic [31:0] a);
        int s = acc_size(f3);
        int m = ((1 << s) - 1) << int'(a[1:0]);
        return 4'(m);
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] w);
        logic [31:0] v;
        int s = acc_size(f3);
        v = w >> (8 * int'(a[1:0]));
        if (s == 1) begin
            v = v & 32'h0000_00FF;
            if (f3 == 3'b000 && v >= 32'd128) v = v | 32'hFFFF_FF00;
        end else if (s == 2) begin
            v = v & 32'h0000_FFFF;
            if (f3 == 3'b001 && v >= 32'd32768) v = v | 32'hFFFF_0000;
        end
        return v;
    endfunction

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            chk("stall_M",   32'(stall_M),   32'(e_stall));
            chk("mem_valid", 32'(mem_valid), 32'(e_valid));
            chk("err",       32'(err),       32'(e_err));
            chk("err_code",  32'(err_code),  32'(e_code));
            if (e_valid) begin
                chk("mem_wen",   32'(mem_wen),   32'(e_wen));
                chk("mem_addr",  mem_addr,       e_addr);
                chk("mem_wmask", 32'(mem_wmask), 32'(e_mask));
                seen_mask = mem_wmask;
                if (chk_wd) begin
                    chk("mem_wdata", mem_wdata, e_wdata);
                    seen_wdata = mem_wdata;
                end
            end
            if (chk_rd) begin
                chk("ReadData_M", ReadData_M, e_rd);
                seen_rd = ReadData_M;
            end
        end
    end

    // One request: wt = ACCESS cycles without ready before ready (>= T means never).
    task automatic txn(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdw,
                       input int wt, input logic early_ready);
        logic [1:0] code;
        logic       tmo;
        int         nacc;
        code = ref_code(rd, wr, f3, a);
        MemRead_M = rd; MemWrite_M = wr; funct3_M = f3; addr_M = a; wdata_M = wd;
        mem_rdata = rdw; mem_ready = early_ready;
        chk_wd = 1'b0;
        chk_en = 1'b1;
        if (code != 2'b00) begin
            e_stall = 1'b0; e_valid = 1'b0; e_err = 1'b1; e_code = code;
            e_rd = 32'h0; chk_rd = 1'b1;
            @(posedge clk); #1;
        end else begin
            tmo  = (wt >= T);
            nacc = tmo ? T : wt + 1;
            e_stall = 1'b1; e_valid = 1'b0; e_err = 1'b0; e_code = 2'b00; chk_rd = 1'b0;
            @(posedge clk); #1;
            for (int j = 0; j < nacc; j++) begin
                mem_ready = (j == wt);
                e_stall = 1'b1; e_valid = 1'b1; e_wen = wr;
                e_addr  = a & 32'hFFFF_FFFC;
                e_mask  = wr ? ref_st_mask(f3, a) : 4'h0;
                e_wdata = ref_st_word(f3, wd);
                chk_wd  = wr;
                @(posedge clk); #1;
            end
            mem_ready = 1'b0;
            e_stall = 1'b0; e_valid = 1'b0; e_err = tmo; e_code = tmo ? 2'b11 : 2'b00;
            chk_wd = 1'b0; chk_rd = rd;
            e_rd = ref_load(f3, a, tmo ? 32'h0 : rdw);
            @(posedge clk); #1;
        end
        chk_en = 1'b0; chk_rd = 1'b0;
        MemRead_M = 1'b0; MemWrite_M = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; MemRead_M = 1'b0; MemWrite_M = 1'b0; funct3_M = 3'b000;
        addr_M = 32'h0; wdata_M = 32'h0; mem_rdata = 32'h0; mem_ready = 1'b0;
        seen_rd = 32'h0; seen_wdata = 32'h0; seen_mask = 8'h0;
        #1;
        chk("rst stall_M",   32'(stall_M),   32'h0);
        chk("rst mem_valid", 32'(mem_valid), 32'h0);
        chk("rst mem_wen",   32'(mem_wen),   32'h0);
        chk("rst mem_wmask", 32'(mem_wmask), 32'h0);
        chk("rst mem_addr",  mem_addr,       32'h0);
        chk("rst mem_wdata", mem_wdata,      32'h0);
        chk("rst ReadData",  ReadData_M,     32'h0);
        chk("rst err",       32'(err),       32'h0);
        chk("rst err_code",  32'(err_code),  32'h0);
        @(posedge clk); #1;
        rst = 1'b1;

        // loads
        txn(1'b1, 1'b0, 3'b010, 32'h1000, 32'h0, 32'hDEAD_BEEF, 0, 1'b0);
        chk("LW lit", seen_rd, 32'hDEAD_BEEF);
        txn(1'b1, 1'b0, 3'b000, 32'h1003, 32'h0, 32'h8011_2233, 0, 1'b0);
        chk("LB lit", seen_rd, 32'hFFFF_FF80);
        txn(1'b1, 1'b0, 3'b100, 32'h1003, 32'h0, 32'h8011_2233, 0, 1'b0);
        chk("LBU lit", seen_rd, 32'h0000_0080);
        txn(1'b1, 1'b0, 3'b101, 32'h1002, 32'h0, 32'h8011_2233, 0, 1'b0);
        chk("LHU lit", seen_rd, 32'h0000_8011);
        txn(1'b1, 1'b0, 3'b001, 32'h1002, 32'h0, 32'h8011_2233, 1, 1'b1);
        chk("LH lit", seen_rd, 32'hFFFF_8011);
        txn(1'b1, 1'b0, 3'b001, 32'h1000, 32'h0, 32'h8011_2233, 2, 1'b0);
        txn(1'b1, 1'b0, 3'b000, 32'h1001, 32'h0, 32'h8011_2233, 0, 1'b0);

        // stores
        txn(1'b0, 1'b1, 3'b000, 32'h2001, 32'h0000_00AB, 32'h0, 0, 1'b0);
        chk("SB wdata lit", seen_wdata, 32'hABAB_ABAB);
        chk("SB mask lit",  32'(seen_mask), 32'h02);
        txn(1'b0, 1'b1, 3'b001, 32'h2002, 32'h0000_1234, 32'h0, 0, 1'b0);
        chk("SH wdata lit", seen_wdata, 32'h1234_1234);
        chk("SH mask lit",  32'(seen_mask), 32'h0C);
        txn(1'b0, 1'b1, 3'b010, 32'h2004, 32'hCAFE_F00D, 32'h0, 1, 1'b1);
        txn(1'b0, 1'b1, 3'b000, 32'h2003, 32'h5A5A_5A77, 32'h0, 0, 1'b0);

        // errors
        txn(1'b1, 1'b0, 3'b010, 32'h1002, 32'h0, 32'h0, 0, 1'b0);
        txn(1'b1, 1'b1, 3'b010, 32'h1000, 32'h0, 32'h0, 0, 1'b0);
        txn(1'b1, 1'b0, 3'b011, 32'h1000, 32'h0, 32'h0, 0, 1'b0);
        txn(1'b0, 1'b1, 3'b100, 32'h1000, 32'h0, 32'h0, 0, 1'b0);
        txn(1'b0, 1'b1, 3'b001, 32'h1001, 32'h0, 32'h0, 0, 1'b0);

        // timeout and ready on the final counted cycle
        txn(1'b1, 1'b0, 3'b010, 32'h1000, 32'h0, 32'h1111_2222, 10, 1'b0);
        chk("timeout data lit", seen_rd, 32'h0);
        txn(1'b1, 1'b0, 3'b010, 32'h1000, 32'h0, 32'h3333_4444, T - 1, 1'b0);
        chk("last-cycle ready lit", seen_rd, 32'h3333_4444);

        // asynchronous reset during an ACCESS wait
        MemRead_M = 1'b1; funct3_M = 3'b010; addr_M = 32'h3000; mem_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre-reset mem_valid", 32'(mem_valid), 32'h1);
        rst = 1'b0;
        #1;
        chk("async rst mem_valid", 32'(mem_valid), 32'h0);
        chk("async rst stall_M",   32'(stall_M),   32'h0);
        MemRead_M = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        txn(1'b1, 1'b0, 3'b010, 32'h3000, 32'h0, 32'h0BAD_F00D, 1, 1'b0);
        chk("post-reset LW lit", seen_rd, 32'h0BAD_F00D);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
